// File: rtl/adc_init_pkg.sv
// Shared types and constants for the ADC power-up sequencer and its serial shifter.
package adc_init_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned WAIT_W = 32;
  localparam int unsigned BIT_W  = 4;

  localparam logic [7:0] ADC_REG_OUTMODE = 8'h41;
  localparam logic [7:0] ADC_OUT_CMOS    = 8'hC0;
  localparam logic [7:0] ADC_REG_RESET   = 8'h00;
  localparam logic [7:0] ADC_SWRST       = 8'h02;

  typedef enum logic [2:0] {
    S_PWR,
    S_HWRST,
    S_RWAIT,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_SHIFT
  } spi_phase_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } spi_word_t;

endpackage

// File: rtl/adc_spi_shifter.sv
// Frames one 16-bit ADC serial write: SEN low, H-cycle setup, then 16 SCLK
// periods of 2H cycles with data changing on the falling edge, MSB first.
module adc_spi_shifter
  import adc_init_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  spi_word_t word,
  output logic      sen,
  output logic      sclk,
  output logic      sdata,
  output logic      busy,
  output logic      last_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  spi_phase_t        phase, phase_n;
  logic [DIV_W-1:0]  div, div_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [WORD_W-2:0] shreg, shreg_n;
  logic              sen_n, sclk_n, sdata_n;
  logic              div_end;

  assign div_end = (div == DIV_LAST);
  assign last_c  = (phase == SPI_SHIFT) && div_end && !sclk && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= SPI_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sen     <= 1'b1;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      phase   <= phase_n;
      div     <= div_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      sen     <= sen_n;
      sclk    <= sclk_n;
      sdata   <= sdata_n;
      busy    <= (phase_n != SPI_IDLE);
    end
  end

  // shreg[MSB] always holds the bit to present at the next SCLK falling edge
  always_comb begin
    phase_n = phase;
    div_n   = div;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    sen_n   = sen;
    sclk_n  = sclk;
    sdata_n = sdata;
    case (phase)
      SPI_IDLE: begin
        if (start) begin
          phase_n = SPI_SETUP;
          div_n   = '0;
          shreg_n = word[WORD_W-2:0];
          sen_n   = 1'b0;
          sclk_n  = 1'b0;
          sdata_n = word[WORD_W-1];
        end
      end
      SPI_SETUP: begin
        if (div_end) begin
          phase_n = SPI_SHIFT;
          div_n   = '0;
          bit_n   = '0;
          sclk_n  = 1'b1;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      SPI_SHIFT: begin
        if (!div_end) begin
          div_n = div + DIV_W'(1);
        end else begin
          div_n = '0;
          if (sclk) begin
            sclk_n  = 1'b0;
            sdata_n = shreg[WORD_W-2];
            shreg_n = {shreg[WORD_W-3:0], 1'b0};
          end else if (bit_cnt == BIT_LAST) begin
            phase_n = SPI_IDLE;
            sen_n   = 1'b1;
            sdata_n = 1'b0;
          end else begin
            bit_n  = bit_cnt + BIT_W'(1);
            sclk_n = 1'b1;
          end
        end
      end
      default: phase_n = SPI_IDLE;
    endcase
  end

endmodule

// File: rtl/adc_init_seq.sv
// One-shot ADC power-up sequencer: supply settle wait, reset, then one CMOS-mode write.
// Build macro ADC_SOFT_RESET_EN replaces the hardware RESET pulse with a soft-reset serial write.
module adc_init_seq
  import adc_init_pkg::*;
#(
  parameter int unsigned PWR_WAIT  = 2000,
  parameter int unsigned RST_LEN   = 4,
  parameter int unsigned RST_WAIT  = 200,
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [15:0] INIT_WORD = {ADC_REG_OUTMODE, ADC_OUT_CMOS}
) (
  input  logic clk,
  input  logic rst,
  output logic sen,
  output logic sclk,
  output logic sdata,
  output logic reset,
  output logic done
);

`ifdef ADC_SOFT_RESET_EN
  localparam bit SOFT_RST = 1'b1;
`else
  localparam bit SOFT_RST = 1'b0;
`endif

  // S_PWR counts from the reset cycle, so its terminal value is PWR_WAIT, not PWR_WAIT-1
  localparam logic [WAIT_W-1:0] PWR_LAST   = WAIT_W'(PWR_WAIT);
  localparam logic [WAIT_W-1:0] RST_LAST   = WAIT_W'(RST_LEN - 1);
  localparam logic [WAIT_W-1:0] RWAIT_LAST = WAIT_W'(RST_WAIT - 1);
  localparam logic [WAIT_W-1:0] HALF_LAST  = WAIT_W'(CLK_DIV - 1);
  localparam spi_word_t SWRST_WORD = spi_word_t'({ADC_REG_RESET, ADC_SWRST});

  state_t            state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic              sw_done, sw_done_n;
  logic              start_c;
  spi_word_t         word_c;
  logic              spi_busy, spi_last_c;

  adc_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .word  (word_c),
    .sen   (sen),
    .sclk  (sclk),
    .sdata (sdata),
    .busy  (spi_busy),
    .last_c(spi_last_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_PWR;
      cnt     <= '0;
      sw_done <= !SOFT_RST;
      reset   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sw_done <= sw_done_n;
      reset   <= (state_n == S_HWRST);
      done    <= (state_n == S_DONE);
    end
  end

  // sw_done stays 1 in the hardware-reset build, so only INIT_WORD is ever sent there
  always_comb begin
    state_n   = state;
    sw_done_n = sw_done;
    start_c   = 1'b0;
    word_c    = sw_done ? spi_word_t'(INIT_WORD) : SWRST_WORD;
    case (state)
      S_PWR: begin
        if (cnt >= PWR_LAST && !spi_busy) begin
          start_c = SOFT_RST;
          state_n = SOFT_RST ? S_SETUP : S_HWRST;
        end
      end
      S_HWRST: if (cnt >= RST_LAST) state_n = S_RWAIT;
      S_RWAIT: begin
        if (cnt >= RWAIT_LAST && !spi_busy) begin
          start_c = 1'b1;
          state_n = S_SETUP;
        end
      end
      S_SETUP: if (cnt >= HALF_LAST) state_n = S_SHIFT;
      S_SHIFT: begin
        if (spi_last_c) begin
          if (!sw_done) begin
            sw_done_n = 1'b1;
            state_n   = S_HOLD;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_HOLD:  if (cnt >= HALF_LAST) state_n = S_RWAIT;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_PWR;
    endcase

    if (state_n != state)     cnt_n = '0;
    else if (state == S_DONE) cnt_n = cnt;
    else                      cnt_n = cnt + WAIT_W'(1);
  end

endmodule

// File: tb/tb_adc_init_seq.sv
// Directed bench for adc_init_seq: two instances (CLK_DIV=2 / 0x41C0 and CLK_DIV=1 / 0xA55A)
// checked against hand-computed cycle tables plus SCLK-edge word capture.
module tb_adc_init_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_sen, a_sclk, a_sdata, a_reset, a_done;
  logic b_sen, b_sclk, b_sdata, b_reset, b_done;

  always #5 clk = ~clk;

  adc_init_seq #(
    .PWR_WAIT(10), .RST_LEN(4), .RST_WAIT(5), .CLK_DIV(2), .INIT_WORD(16'h41C0)
  ) dut_a (
    .clk(clk), .rst(rst), .sen(a_sen), .sclk(a_sclk), .sdata(a_sdata),
    .reset(a_reset), .done(a_done)
  );

  adc_init_seq #(
    .PWR_WAIT(10), .RST_LEN(4), .RST_WAIT(5), .CLK_DIV(1), .INIT_WORD(16'hA55A)
  ) dut_b (
    .clk(clk), .rst(rst), .sen(b_sen), .sclk(b_sclk), .sdata(b_sdata),
    .reset(b_reset), .done(b_done)
  );

`ifdef ADC_SOFT_RESET_EN
  localparam int          EDGES   = 32;
  localparam logic [31:0] A_BITS  = 32'h0002_41C0;
  localparam logic [31:0] B_BITS  = 32'h0002_A55A;
  localparam int          A_FIRST = 12;
  localparam int          B_FIRST = 11;
  localparam int          RST_CYC = 0;
`else
  localparam int          EDGES   = 16;
  localparam logic [31:0] A_BITS  = 32'h0000_41C0;
  localparam logic [31:0] B_BITS  = 32'h0000_A55A;
  localparam int          A_FIRST = 21;
  localparam int          B_FIRST = 20;
  localparam int          RST_CYC = 4;
`endif

  // exp packs {sen, sclk, sdata, reset, done}
  typedef struct {
    int         unit;
    int         cyc;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    int          edges;
    logic [31:0] bits;
    logic        prev;
    int          first;
    int          last;
    int          gap_bad;
    int          sen_bad;
    int          overlap;
    int          rst_cycles;
  } mon_t;

  vec_t vecs[$];
  mon_t ma, mb;
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = -1;

  function automatic void add(input int u, input int c, input logic [4:0] e);
    vec_t v;
    v.unit = u;
    v.cyc  = c;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int u, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s unit=%0d cyc=%0d got=%0h want=%0h", name, u, c, act, exp);
    end
  endtask

  task automatic mon(input logic sen, input logic sclk, input logic sdata,
                     input logic reset, input int spacing, inout mon_t m);
    if (sclk && !m.prev) begin
      if (m.edges == 0) m.first = cyc;
      else if ((m.edges % 16) != 0 && cyc != m.last + spacing) m.gap_bad++;
      if (sen) m.sen_bad++;
      m.last  = cyc;
      m.bits  = {m.bits[30:0], sdata};
      m.edges++;
    end
    if (!sen && reset) m.overlap++;
    if (reset) m.rst_cycles++;
    m.prev = sclk;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mon(a_sen, a_sclk, a_sdata, a_reset, 4, ma);
    mon(b_sen, b_sclk, b_sdata, b_reset, 2, mb);
  endtask

  task automatic idle_chk(input string name);
    chk(name, 0, cyc, 32'({a_sen, a_sclk, a_sdata, a_reset, a_done}), 32'(5'b10000));
    chk(name, 1, cyc, 32'({b_sen, b_sclk, b_sdata, b_reset, b_done}), 32'(5'b10000));
  endtask

  task automatic run_seq(input int ncyc);
    cyc = -1;
    ma  = '{default: 0};
    mb  = '{default: 0};
    for (int i = 0; i < ncyc; i++) begin
      step();
      foreach (vecs[j]) begin
        if (vecs[j].cyc == cyc) begin
          if (vecs[j].unit == 0)
            chk("vec", 0, cyc, 32'({a_sen, a_sclk, a_sdata, a_reset, a_done}), 32'(vecs[j].exp));
          else
            chk("vec", 1, cyc, 32'({b_sen, b_sclk, b_sdata, b_reset, b_done}), 32'(vecs[j].exp));
        end
      end
    end
    chk("edges",     0, cyc, 32'(ma.edges),      32'(EDGES));
    chk("word",      0, cyc, ma.bits,            A_BITS);
    chk("first_edge",0, cyc, 32'(ma.first),      32'(A_FIRST));
    chk("edge_gap",  0, cyc, 32'(ma.gap_bad),    32'(0));
    chk("edge_sen",  0, cyc, 32'(ma.sen_bad),    32'(0));
    chk("sen_reset", 0, cyc, 32'(ma.overlap),    32'(0));
    chk("reset_len", 0, cyc, 32'(ma.rst_cycles), 32'(RST_CYC));
    chk("edges",     1, cyc, 32'(mb.edges),      32'(EDGES));
    chk("word",      1, cyc, mb.bits,            B_BITS);
    chk("first_edge",1, cyc, 32'(mb.first),      32'(B_FIRST));
    chk("edge_gap",  1, cyc, 32'(mb.gap_bad),    32'(0));
    chk("edge_sen",  1, cyc, 32'(mb.sen_bad),    32'(0));
    chk("sen_reset", 1, cyc, 32'(mb.overlap),    32'(0));
    chk("reset_len", 1, cyc, 32'(mb.rst_cycles), 32'(RST_CYC));
  endtask

  initial begin
`ifdef ADC_SOFT_RESET_EN
    add(0, 9, 5'b10000);   add(0, 10, 5'b00000);  add(0, 12, 5'b01000);
    add(0, 13, 5'b01000);  add(0, 14, 5'b00000);  add(0, 75, 5'b00000);
    add(0, 76, 5'b10000);  add(0, 77, 5'b10000);  add(0, 82, 5'b10000);
    add(0, 83, 5'b00000);  add(0, 85, 5'b01000);  add(0, 87, 5'b00100);
    add(0, 148, 5'b00000); add(0, 149, 5'b10001); add(0, 1000, 5'b10001);
    add(1, 10, 5'b00000);  add(1, 11, 5'b01000);  add(1, 42, 5'b00000);
    add(1, 43, 5'b10000);  add(1, 48, 5'b10000);  add(1, 49, 5'b00100);
    add(1, 50, 5'b01100);  add(1, 51, 5'b00000);  add(1, 81, 5'b00000);
    add(1, 82, 5'b10001);  add(1, 1000, 5'b10001);
`else
    add(0, 0, 5'b10000);   add(0, 9, 5'b10000);   add(0, 10, 5'b10010);
    add(0, 13, 5'b10010);  add(0, 14, 5'b10000);  add(0, 18, 5'b10000);
    add(0, 19, 5'b00000);  add(0, 20, 5'b00000);  add(0, 21, 5'b01000);
    add(0, 22, 5'b01000);  add(0, 23, 5'b00100);  add(0, 46, 5'b01000);
    add(0, 47, 5'b00100);  add(0, 84, 5'b00000);  add(0, 85, 5'b10001);
    add(0, 1000, 5'b10001);
    add(1, 10, 5'b10010);  add(1, 18, 5'b10000);  add(1, 19, 5'b00100);
    add(1, 20, 5'b01100);  add(1, 21, 5'b00000);  add(1, 22, 5'b01000);
    add(1, 23, 5'b00100);  add(1, 51, 5'b00000);  add(1, 52, 5'b10001);
    add(1, 1000, 5'b10001);
`endif

    // power-on reset, then a full sequence plus a long idle tail
    rst = 1'b1;
    repeat (3) @(negedge clk);
    idle_chk("rst_idle");
    rst = 1'b0;
    run_seq(1160);
    chk("done_sticky", 0, cyc, 32'(a_done),  32'(1));
    chk("reset_low",   0, cyc, 32'(a_reset), 32'(0));
    chk("done_sticky", 1, cyc, 32'(b_done),  32'(1));
    chk("reset_low",   1, cyc, 32'(b_reset), 32'(0));

    // restart, then a one-cycle rst pulse in the middle of the word
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
    repeat (40) step();
    chk("pre_pulse_sen", 0, cyc, 32'(a_sen), 32'(0));
    chk("pre_pulse_sen", 1, cyc, 32'(b_sen), 32'(0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle_chk("mid_rst_idle");
    rst = 1'b0;
    run_seq(1160);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
